imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_ram.sv | 31 +++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - state_e : loader FSM states (CSUM exists only when the optional
//               checksum is compiled in via IMEM_LOADER_CHECKSUM_EN)
//   - NOP     : word returned for fetches outside the memory window
//   - HDR_W   : width of the little-endian word-count header
package imem_pkg;

  localparam int          HDR_W = 16;
  localparam logic [31:0] NOP   = 32'h0000_0033;  // add $0,$0,$0

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    WORD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the byte-stream source / CPU fetch port and the loader.
//   rx_data/rx_valid/rx_ready : load-stream byte handshake
//   instrAddr/instr           : CPU byte fetch address and returned word
// Handshake: a byte moves on a rising edge only when rx_valid && rx_ready are
// both high; rx_data offered while rx_ready is low (or with rx_valid low) is
// not consumed and may change freely.
// Modports: master = stream source / CPU side, slave = loader side.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] instrAddr;
  logic [31:0] instr;

  modport master (
    output rx_data, rx_valid, instrAddr,
    input  rx_ready, instr
  );

  modport slave (
    input  rx_data, rx_valid, instrAddr,
    output rx_ready, instr
  );
endinterface

// File: rtl/imem_ram.sv
// Instruction storage: DEPTH x 32-bit words, synchronous write, asynchronous
// read. Contents are never reset.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write word index
//   wdata_i  : write data
//   raddr_i  : read word index
//   rdata_o  : read data (combinational)
module imem_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Boot loader for an instruction memory. Receives a byte stream
//   N[7:0] N[15:8] | word0 (LE, 4 bytes) | ... | word N-1 [| checksum]
// writes word k to memory index k, then releases the CPU from reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum
// byte; the load succeeds only if the 8-bit sum of all bytes including it is 0.
// Ports:
//   clk, n_reset  : clock, synchronous active-low reset
//   bus (slave)   : byte handshake in, CPU fetch address in / word out
//   cpu_n_reset   : high only once the load completed (state DONE)
//   loading       : high while accepting stream bytes
//   load_err      : high in ERR (oversize header or bad checksum)
//   state_o       : FSM state, for debug/observation
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          n_reset,
  imem_loader_if.slave  bus,
  output logic          cpu_n_reset,
  output logic          loading,
  output logic          load_err,
  output state_e        state_o
);

  localparam int             ADDR_W  = $clog2(DEPTH);
  localparam logic [HDR_W:0] DEPTH_L = (HDR_W + 1)'(DEPTH);

  state_e            state_q;
  logic [1:0]        byte_q;
  logic [ADDR_W-1:0] word_q;
  logic [23:0]       asm_q;
  logic [HDR_W-1:0]  n_q;

  logic              xfer;
  logic [HDR_W-1:0]  n_hdr_d;
  logic              last_word_d;
  logic              we_d;
  logic [31:0]       wdata_d;
  logic [31:0]       ram_rdata;
  logic              addr_oob;
  logic              unused_addr_bits;

  // Status outputs decode straight from the state register.
  assign loading     = (state_q != DONE) && (state_q != ERR);
  assign bus.rx_ready = loading;
  assign cpu_n_reset = (state_q == DONE);
  assign load_err    = (state_q == ERR);
  assign state_o     = state_q;

  assign xfer        = bus.rx_valid && bus.rx_ready;
  assign n_hdr_d     = {bus.rx_data, n_q[7:0]};
  assign last_word_d = (HDR_W'(word_q) == (n_q - 1'b1));
  assign wdata_d     = {bus.rx_data, asm_q};
  // A 4th byte arriving on a reset edge must not land in memory.
  assign we_d        = n_reset && xfer && (state_q == WORD) && (byte_q == 2'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_d;
  assign sum_d = sum_q + bus.rx_data;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= HDR0;
      byte_q  <= '0;
      word_q  <= '0;
      asm_q   <= '0;
      n_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q <= sum_d;
`endif
      case (state_q)
        HDR0: begin
          n_q[7:0] <= bus.rx_data;
          state_q  <= HDR1;
        end
        HDR1: begin
          n_q[15:8] <= bus.rx_data;
          byte_q    <= '0;
          word_q    <= '0;
          if ({1'b0, n_hdr_d} > DEPTH_L) begin
            state_q <= ERR;
          end else if (n_hdr_d == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q <= CSUM;
`else
            state_q <= DONE;
`endif
          end else begin
            state_q <= WORD;
          end
        end
        WORD: begin
          byte_q <= byte_q + 2'd1;
          case (byte_q)
            2'd0: asm_q[7:0]   <= bus.rx_data;
            2'd1: asm_q[15:8]  <= bus.rx_data;
            2'd2: asm_q[23:16] <= bus.rx_data;
            default: begin
              // 4th byte: the RAM write happens on this same edge.
              word_q <= word_q + 1'b1;
              if (last_word_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_q <= CSUM;
`else
                state_q <= DONE;
`endif
              end
            end
          endcase
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          state_q <= (sum_d == 8'h00) ? DONE : ERR;
        end
`endif
        default: begin
          state_q <= state_q;  // DONE / ERR leave only through reset
        end
      endcase
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_d),
    .waddr_i (word_q),
    .wdata_i (wdata_d),
    .raddr_i (bus.instrAddr[ADDR_W+1:2]),
    .rdata_o (ram_rdata)
  );

  // Fetches above the memory window read as NOP; byte offset is ignored.
  assign addr_oob         = |bus.instrAddr[31:ADDR_W+2];
  assign unused_addr_bits = ^bus.instrAddr[1:0];
  assign bus.instr        = addr_oob ? NOP : ram_rdata;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_pkg::*;

  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  imem_loader_if bus ();
  logic   cpu_n_reset;
  logic   loading;
  logic   load_err;
  state_e state_o;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .bus         (bus),
    .cpu_n_reset (cpu_n_reset),
    .loading     (loading),
    .load_err    (load_err),
    .state_o     (state_o)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  stream_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    bus.rx_valid = 1'b0;
    n_reset      = 1'b0;
    repeat (2) @(negedge clk);
    n_reset      = 1'b1;
  endtask

  // Offers one byte at a negedge and waits (bounded) for it to be taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    if (gap) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 16 && !ok; t++) begin
      if (bus.rx_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    if (!ok) chk("rx_ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic push_header(input logic [15:0] n);
    stream_q.push_back(n[7:0]);
    stream_q.push_back(n[15:8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) stream_q.push_back(w[8*i +: 8]);
  endtask

  // Sends the queued stream; cpu_n_reset must stay low until the last byte.
  task automatic send_stream(input bit gap, input string tag);
    logic [7:0] s;
    int         len;
    s = 8'h00;
    foreach (stream_q[i]) s = s + stream_q[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q.push_back(8'h00 - s);
`endif
    len = stream_q.size();
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) chk({tag, "_cpu_rst_before_last"}, 32'(cpu_n_reset), 32'd0);
      send_byte(stream_q[i], gap);
    end
    chk({tag, "_cpu_rst_after_last"}, 32'(cpu_n_reset), 32'd1);
    stream_q.delete();
  endtask

  task automatic check_image(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.instrAddr = 32'(i * 4);
      #1;
      chk(tag, bus.instr, exp_q.pop_front());
    end
  endtask

  task automatic read_at(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.instrAddr = addr;
    #1;
    chk(tag, bus.instr, exp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  logic [31:0] w_keep;
  logic [31:0] w_b;

  initial begin
    n_reset       = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.instrAddr = 32'h0;

    // Reset state
    do_reset();
    chk("rst_cpu_n_reset", 32'(cpu_n_reset), 32'd0);
    chk("rst_loading",     32'(loading),     32'd1);
    chk("rst_load_err",    32'(load_err),    32'd0);
    chk("rst_rx_ready",    32'(bus.rx_ready), 32'd1);
    chk("rst_state",       32'(state_o),     32'(HDR0));

    // Basic two-word load
    push_header(16'd2);
    push_word(32'h0F00_0093);
    push_word(32'h0010_8133);
    send_stream(1'b0, "basic");
    chk("basic_state",    32'(state_o),      32'(DONE));
    chk("basic_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("basic_loading",  32'(loading),      32'd0);
    check_image("basic_img", 2);
    read_at("addr_low_bits_ignored", 32'h0000_0006, 32'h0010_8133);
    read_at("addr_byte3",            32'h0000_0003, 32'h0F00_0093);
    read_at("addr_oob_msb",          32'h8000_0000, NOP);
    read_at("addr_oob_first",        32'h0000_0400, NOP);
    repeat (3) @(negedge clk);
    chk("done_holds", 32'(state_o), 32'(DONE));

    // Random three-word image
    do_reset();
    push_header(16'd3);
    push_word($urandom);
    push_word($urandom);
    w_keep = $urandom;
    push_word(w_keep);
    send_stream(1'b0, "rand3");
    check_image("rand3_img", 3);

    // rx_valid toggling every cycle; word 2 must keep its old contents
    do_reset();
    push_header(16'd2);
    push_word(32'h0F00_0093);
    push_word(32'h0010_8133);
    send_stream(1'b1, "toggle");
    check_image("toggle_img", 2);
    read_at("retain_above_n", 32'h0000_0008, w_keep);

    // Reset on the edge that would accept the 4th byte of word 0
    do_reset();
    push_header(16'd1);
    w_b = $urandom;
    push_word(w_b);
    send_stream(1'b0, "preload");
    check_image("preload_img", 1);
    do_reset();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h22, 1'b0);
    bus.rx_data  = 8'h11;
    bus.rx_valid = 1'b1;
    n_reset      = 1'b0;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    n_reset      = 1'b1;
    chk("abort_state",    32'(state_o), 32'(HDR0));
    chk("abort_loading",  32'(loading), 32'd1);
    read_at("abort_no_write", 32'h0, w_b);
    push_header(16'd2);
    push_word(32'h0F00_0093);
    push_word(32'h0010_8133);
    send_stream(1'b0, "reload");
    check_image("reload_img", 2);

    // Header N = DEPTH is accepted
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("n_eq_depth_state", 32'(state_o), 32'(WORD));

    // Header N = DEPTH+1 -> ERR
    do_reset();
    send_byte(8'h01, 1'b0);
    chk("err_hdr0_state", 32'(state_o), 32'(HDR1));
    send_byte(8'h01, 1'b0);
    chk("err_state",       32'(state_o),      32'(ERR));
    chk("err_load_err",    32'(load_err),     32'd1);
    chk("err_rx_ready",    32'(bus.rx_ready), 32'd0);
    chk("err_loading",     32'(loading),      32'd0);
    chk("err_cpu_n_reset", 32'(cpu_n_reset),  32'd0);
    repeat (3) @(negedge clk);
    chk("err_holds",       32'(state_o),      32'(ERR));
    chk("err_cpu_stays",   32'(cpu_n_reset),  32'd0);
    read_at("err_mem_kept", 32'h0, 32'h0F00_0093);

    // Empty load
    do_reset();
    push_header(16'd0);
    send_stream(1'b0, "empty");
    chk("empty_load_err", 32'(load_err), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte -> ERR
    do_reset();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h81, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("csum_wait_state", 32'(state_o), 32'(CSUM));
    send_byte(8'h8E, 1'b0);
    chk("csum_bad_state",    32'(state_o),     32'(ERR));
    chk("csum_bad_load_err", 32'(load_err),    32'd1);
    chk("csum_bad_cpu",      32'(cpu_n_reset), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
